// File: rtl/req_ack_responder.sv
// Responder for the req/ack handshake. It returns a registered ack ACK_DELAY cycles after each
// accepted req, holds off new requests for MIN_GAP cycles, and flags dropped requests in a sticky err.
module req_ack_responder #(
  parameter int ACK_DELAY = 4,
  parameter int MIN_GAP   = 8,
  parameter int CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic             i_err_clr,
  output logic             o_ack,
  output logic             o_busy,
  output logic             o_err,
  output logic [CNT_W-1:0] o_ack_count
);

  localparam int            TW         = $clog2(MIN_GAP + 1);
  localparam logic [TW-1:0] LP_T_ZERO  = TW'(0);
  localparam logic [TW-1:0] LP_T_ONE   = TW'(1);
  localparam logic [TW-1:0] LP_T_ACK   = TW'(ACK_DELAY);
  localparam logic [TW-1:0] LP_T_END   = TW'(MIN_GAP - 1);
  localparam logic          LP_NO_GAP  = (ACK_DELAY == (MIN_GAP - 1));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TW-1:0]    r_t;
  logic [TW-1:0]    w_t_nxt;
  logic             r_ack;
  logic             w_ack_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_viol;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State and cycle timer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_t     <= LP_T_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // Next-state and timer decode; requests outside IDLE never restart the timer.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_state_nxt = ST_DELAY;
          w_t_nxt     = LP_T_ONE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_t_nxt     = LP_T_ZERO;
        end
      end
      ST_DELAY: begin
        if (r_t == LP_T_ACK) begin
          if (LP_NO_GAP) begin
            w_state_nxt = ST_IDLE;
            w_t_nxt     = LP_T_ZERO;
          end else begin
            w_state_nxt = ST_GAP;
            w_t_nxt     = r_t + LP_T_ONE;
          end
        end else begin
          w_state_nxt = ST_DELAY;
          w_t_nxt     = r_t + LP_T_ONE;
        end
      end
      ST_GAP: begin
        if (r_t == LP_T_END) begin
          w_state_nxt = ST_IDLE;
          w_t_nxt     = LP_T_ZERO;
        end else begin
          w_state_nxt = ST_GAP;
          w_t_nxt     = r_t + LP_T_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_t_nxt     = LP_T_ZERO;
      end
    endcase
  end

  // Output decode: ack is pre-computed from the next state so it can be registered.
  always_comb begin
    w_viol    = 1'b0;
    w_ack_nxt = 1'b0;
    w_err_nxt = r_err;
    w_cnt_nxt = r_cnt;

    if ((w_state_nxt == ST_DELAY) && (w_t_nxt == LP_T_ACK)) begin
      w_ack_nxt = 1'b1;
    end else begin
      w_ack_nxt = 1'b0;
    end

    if (i_req && (r_state != ST_IDLE)) begin
      w_viol = 1'b1;
    end else begin
      w_viol = 1'b0;
    end

    // A violation in the same cycle as a clear still leaves err set.
    if (w_viol) begin
      w_err_nxt = 1'b1;
    end else if (i_err_clr) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err;
    end

    if (i_err_clr) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (r_ack) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_ack <= w_ack_nxt;
      r_err <= w_err_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_ack       = r_ack;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_err       = r_err;
  assign o_ack_count = r_cnt;

endmodule

// File: tb/tb_req_ack_responder.sv
// Scoreboard bench for req_ack_responder: a cycle-indexed reference model queues expected ack
// cycles and tracks busy/err/count; a negedge monitor compares every cycle.
module tb_req_ack_responder;

  localparam int ACK_DELAY = 4;
  localparam int MIN_GAP   = 8;
  localparam int CNT_W     = 2;

  logic             clk;
  logic             rst_n;
  logic             req;
  logic             err_clr;
  logic             ack;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] ack_count;

  req_ack_responder #(
    .ACK_DELAY(ACK_DELAY),
    .MIN_GAP  (MIN_GAP),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_err_clr  (err_clr),
    .o_ack      (ack),
    .o_busy     (busy),
    .o_err      (err),
    .o_ack_count(ack_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit started = 1'b0;

  // Reference model: cycle of last accepted req, queue of expected ack cycles.
  int last_acc;
  int ack_q[$];
  bit m_err;
  int m_cnt;

  function automatic bit busy_at(input int c);
    return ((c - last_acc) >= 1) && ((c - last_acc) <= MIN_GAP - 1);
  endfunction

  task automatic model_reset();
    last_acc = -1000;
    ack_q.delete();
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d, required %0d", nm, cyc, got, exp);
    end
  endtask

  // One clock cycle of stimulus; the model advances across the closing edge.
  task automatic step(input bit rq, input bit clr, input bit rst);
    bit bz;
    bit ack_now;
    req     = rq;
    err_clr = clr;
    rst_n   = !rst;
    if (rst) model_reset();
    @(posedge clk);
    #1;
    if (!rst) begin
      bz      = busy_at(cyc);
      ack_now = (cyc == last_acc + ACK_DELAY);
      if (rq && !bz) begin
        last_acc = cyc;
        ack_q.push_back(cyc + ACK_DELAY);
      end
      if (rq && bz) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      if (clr) m_cnt = 0;
      else if (ack_now) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle, pop the scoreboard when an ack is due and check all outputs.
  always @(negedge clk) begin
    bit exp_ack;
    if (started) begin
      exp_ack = (ack_q.size() > 0) && (ack_q[0] == cyc);
      chk("ack", int'(ack), int'(exp_ack));
      if (exp_ack) void'(ack_q.pop_front());
      chk("busy", int'(busy), int'(busy_at(cyc)));
      chk("err", int'(err), int'(m_err));
      chk("ack_count", int'(ack_count), m_cnt);
    end
  end

  initial begin
    req = 1'b0;
    err_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;

    // Single req at cycle 2.
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    idle(12);
    // Two legal reqs exactly MIN_GAP apart.
    step(1'b1, 1'b0, 1'b0);
    idle(7);
    step(1'b1, 1'b0, 1'b0);
    idle(12);
    // Second req one cycle too early.
    step(1'b1, 1'b0, 1'b0);
    idle(6);
    step(1'b1, 1'b0, 1'b0);
    idle(12);
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    // req held for two cycles.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(12);
    step(1'b0, 1'b1, 1'b0);
    // Reset cancels a pending ack; a later req is served normally.
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    idle(12);
    // Five legal reqs wrap the 2-bit count, then a violation coinciding with a clear.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      idle(7);
    end
    idle(4);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 1'b0);
    idle(10);
    // Clear coinciding with an ack-increment.
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    idle(8);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 199) == 0));
    end
    idle(16);

    chk("ack_queue_drained", ack_q.size(), 0);
    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/req_ack_responder.md
# req_ack_responder

Responder stage that consumes single-cycle `req` pulses from an upstream requester and returns a single-cycle `ack` exactly `ACK_DELAY` cycles later. It enforces the request protocol: one-cycle pulses, at least `MIN_GAP` cycles apart. It drops any request that breaks the protocol and raises a sticky error flag for it. It sits directly downstream of the req/ack requester and drives the `ack` line that requester waits on.

## Interface
- `ACK_DELAY`, default 4: cycles from an accepted `req` to its `ack`. Legal range is 1 ≤ `ACK_DELAY` < `MIN_GAP`.
- `MIN_GAP`, default 8: minimum cycle distance between two accepted `req` pulses.
- `CNT_W`, default 8: width of `ack_count`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  1  request pulse from the upstream requester.
- `err_clr`  in  1  synchronous clear of `err` and `ack_count`.
- `ack`  out  1  acknowledge pulse, registered.
- `busy`  out  1  high while a new `req` would be rejected.
- `err`  out  1  sticky protocol-violation flag.
- `ack_count`  out  CNT_W  number of acks issued, modulo 2^CNT_W.

## Operation
- States:
  - IDLE: no request outstanding.
  - DELAY: request accepted, ack not yet issued.
  - GAP: ack issued, holdoff still running.
- Timer `t` counts cycles since the last accepted request; it is 1 in the cycle after acceptance.
- IDLE:
  - `req`=1 → request accepted, go to DELAY with `t`=1 next cycle.
  - `req`=0 → stay in IDLE.
- DELAY: when `t` = `ACK_DELAY`:
  - `ack`=1 for that cycle only;
  - `ack_count` increments at the end of that cycle;
  - go to GAP, or to IDLE if `ACK_DELAY` = `MIN_GAP`-1.
- GAP: return to IDLE after the cycle with `t` = `MIN_GAP`-1.
- `req`=1 while in DELAY or GAP is a violation:
  - the request is dropped, never acked, and does not restart `t`;
  - `err` is set from the next cycle;
  - a `req` held high for two cycles is therefore a violation on its second cycle.
- `busy` = (state ≠ IDLE), i.e. high for cycles k+1 … k+`MIN_GAP`-1 after an accepted `req` at cycle k.
- `err_clr`=1 clears `err` and `ack_count` at the next edge. It does not affect the state, the timer or a pending ack.
- Simultaneous events:
  - violation and `err_clr` in the same cycle → `err` is 1 next cycle (violation wins);
  - ack-increment and `err_clr` in the same cycle → `ack_count` is 0 next cycle (clear wins).
- `ack_count` wraps from 2^CNT_W-1 to 0 with no flag.

## Timing
- Reset (`rst_n`=0): state IDLE, `t`=0, `ack`=0, `busy`=0, `err`=0, `ack_count`=0, all immediately and asynchronously.
- Reset mid-operation cancels any pending ack. No ack appears after `rst_n` deasserts unless a new `req` is accepted.
- Latency: `req` sampled high at cycle k in IDLE → `ack`=1 in cycle k+`ACK_DELAY`, for exactly one cycle, and low in all other cycles.
- `ack` is low in any cycle where no accepted `req` occurred `ACK_DELAY` cycles earlier.
- A `req` at cycle k+`MIN_GAP` is legal and accepted (`busy`=0 in that cycle).
- `err` and `ack_count` change only at clock edges; `busy` is a decode of registered state.

## Test plan
- Single `req` at cycle 2 (defaults) → `ack`=1 only at cycle 6; `busy`=1 for cycles 3–9; `ack_count`=1 from cycle 7; `err`=0.
- `req` at cycles 2 and 10 → acks at cycles 6 and 14; `ack_count`=2; `err` stays 0.
- `req` at cycles 2 and 9 → ack only at 6; no ack at 13; `err`=1 from cycle 10; `ack_count`=1.
- `req` held high for cycles 2–3 → single ack at 6; `err`=1 from cycle 4.
- `req` at cycle 2, `rst_n` low during cycle 4, released at 5 → `ack` never asserts; all outputs 0 from cycle 4; a new `req` at cycle 7 → ack at 11.
- `CNT_W`=2, five legal reqs 8 cycles apart → `ack_count` = 1 after the fifth ack. Then a violation and `err_clr` in the same cycle → `err`=1 and `ack_count`=0 next cycle.
